gnrc_bitscan_iter: RTL and testbench

- Sequential bit-set iterator, the consumer-side inverse of the combinational leading-zero counter: accepts one WIDTH-bit vector, emits the index of every set bit, one per beat, over a valid/ready stream.
- Scan order and index convention match the leading/trailing-zero counter. Beat k's index equals the zero count of the vector after the first k found bits are cleared.
- Used to serialise request/flag masks into per-index work items.

---
 rtl/gnrc_bitscan_iter.sv | 139 +++++++++++++
 tb/tb_gnrc_bitscan_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gnrc_bitscan_iter.sv
// Sequential set-bit iterator: takes one WIDTH-bit vector and streams the zero count
// of each set bit, one beat per handshake, in leading- or trailing-zero order.
module gnrc_bitscan_iter #(
    parameter int WIDTH = 13,
    parameter int MODE  = 0,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_last_o,
    output logic             idx_empty_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [WIDTH-1:0] vec_r;
    logic             empty_r;
    logic [WIDTH-1:0] sel_s;
    logic [IDX_W-1:0] pos_s;
    logic             last_s;
    logic             accept_s;
    logic             beat_s;

    assign accept_s = (state_r == IDLE) && in_valid_i;
    assign beat_s   = (state_r == SCAN) && idx_ready_i;
    assign last_s   = (vec_r & (vec_r - WIDTH'(1))) == '0;

    // Locate the next bit to report; the last write in scan order wins.
    if (MODE == 0) begin : g_msb
        always_comb begin
            pos_s = '0;
            sel_s = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pos_s = vec_r[i] ? IDX_W'(WIDTH - 1 - i) : pos_s;
                sel_s = vec_r[i] ? (WIDTH'(1) << i) : sel_s;
            end
        end
    end else begin : g_lsb
        always_comb begin
            pos_s = '0;
            sel_s = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                pos_s = vec_r[i] ? IDX_W'(i) : pos_s;
                sel_s = vec_r[i] ? (WIDTH'(1) << i) : sel_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; flush overrides both accept and beat.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (in_valid_i) begin
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (idx_ready_i && last_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector and empty-flag storage: bits are only ever cleared while scanning.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vec_r   <= '0;
            empty_r <= 1'b0;
        end else if (flush_i) begin
            vec_r   <= '0;
            empty_r <= 1'b0;
        end else if (accept_s) begin
            vec_r   <= in_i;
            empty_r <= (in_i == '0);
        end else if (beat_s) begin
            vec_r   <= vec_r & ~sel_s;
            empty_r <= last_s ? 1'b0 : empty_r;
        end else begin
            vec_r   <= vec_r;
            empty_r <= empty_r;
        end
    end

    // Output decode; beat fields are forced to zero outside SCAN.
    always_comb begin
        in_ready_o  = 1'b0;
        idx_valid_o = 1'b0;
        idx_o       = '0;
        idx_last_o  = 1'b0;
        idx_empty_o = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_o = 1'b1;
            end
            SCAN: begin
                idx_valid_o = 1'b1;
                idx_o       = empty_r ? '0 : pos_s;
                idx_last_o  = last_s;
                idx_empty_o = empty_r;
            end
            default: begin
                in_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gnrc_bitscan_iter.sv
// Scoreboard bench for gnrc_bitscan_iter: one MSB-first and one LSB-first instance,
// expected beats queued by the stimulus and checked by per-instance monitors.
module tb_gnrc_bitscan_iter;

    typedef struct {
        int idx;
        bit last;
        bit empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        idx_ready;
    logic [12:0] in_vec;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic        idx_valid0, idx_valid1;
    logic [3:0]  idx0, idx1;
    logic        last0, last1;
    logic        empty0, empty1;

    beat_t q0[$];
    beat_t q1[$];
    int    nchk = 0;
    int    nfail = 0;

    always #5 clk = ~clk;

    gnrc_bitscan_iter #(.WIDTH(13), .MODE(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_i(in_vec),
        .idx_valid_o(idx_valid0), .idx_ready_i(idx_ready), .idx_o(idx0),
        .idx_last_o(last0), .idx_empty_o(empty0)
    );

    gnrc_bitscan_iter #(.WIDTH(13), .MODE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_i(in_vec),
        .idx_valid_o(idx_valid1), .idx_ready_i(idx_ready), .idx_o(idx1),
        .idx_last_o(last1), .idx_empty_o(empty1)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int idx, input bit last, input bit empty);
        beat_t b;
        b.idx = idx; b.last = last; b.empty = empty;
        q0.push_back(b);
    endtask

    task automatic push1(input int idx, input bit last, input bit empty);
        beat_t b;
        b.idx = idx; b.last = last; b.empty = empty;
        q1.push_back(b);
    endtask

    task automatic send(input int which, input logic [12:0] v);
        in_vec = v;
        if (which == 0) begin
            chk("in_ready0_before_send", int'(in_ready0), 1);
            in_valid0 = 1'b1;
        end else begin
            chk("in_ready1_before_send", int'(in_ready1), 1);
            in_valid1 = 1'b1;
        end
        tick();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic chk_idle0(input string name);
        chk({name, "_valid"}, int'(idx_valid0), 0);
        chk({name, "_ready"}, int'(in_ready0), 1);
        chk({name, "_qempty"}, q0.size(), 0);
    endtask

    // Monitor for the MSB-first instance: beat compare, stall hold, idle gating.
    bit          st0_prev = 1'b0;
    logic [3:0]  h_idx0;
    logic        h_last0, h_empty0;
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && idx_valid0 && idx_ready) begin
            if (q0.size() == 0) begin
                chk("m0_unexpected_beat", int'(idx0), -1);
            end else begin
                e = q0.pop_front();
                chk("m0_idx", int'(idx0), e.idx);
                chk("m0_last", int'(last0), int'(e.last));
                chk("m0_empty", int'(empty0), int'(e.empty));
            end
        end
        if (st0_prev && rst_n && !flush) begin
            chk("m0_stall_idx", int'(idx0), int'(h_idx0));
            chk("m0_stall_last", int'(last0), int'(h_last0));
            chk("m0_stall_empty", int'(empty0), int'(h_empty0));
        end
        if (!idx_valid0) begin
            chk("m0_gated", int'({idx0, last0, empty0}), 0);
        end
        st0_prev = rst_n && !flush && idx_valid0 && !idx_ready;
        h_idx0   = idx0;
        h_last0  = last0;
        h_empty0 = empty0;
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && idx_valid1 && idx_ready) begin
            if (q1.size() == 0) begin
                chk("m1_unexpected_beat", int'(idx1), -1);
            end else begin
                e = q1.pop_front();
                chk("m1_idx", int'(idx1), e.idx);
                chk("m1_last", int'(last1), int'(e.last));
                chk("m1_empty", int'(empty1), int'(e.empty));
            end
        end
        if (!idx_valid1) begin
            chk("m1_gated", int'({idx1, last1, empty1}), 0);
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; idx_ready = 1'b1;
        in_vec = '0; in_valid0 = 1'b0; in_valid1 = 1'b0;
        tick(); tick();
        chk("rst_ready0", int'(in_ready0), 1);
        chk("rst_valid0", int'(idx_valid0), 0);
        chk("rst_outs0", int'({idx0, last0, empty0}), 0);
        chk("rst_ready1", int'(in_ready1), 1);
        rst_n = 1'b1;
        tick();

        // 1: MSB scan of bits 9,8,4,2
        push0(3, 0, 0); push0(4, 0, 0); push0(8, 0, 0); push0(10, 1, 0);
        send(0, 13'h0314);
        chk("t1_first_valid", int'(idx_valid0), 1);
        repeat (4) tick();
        chk_idle0("t1_end");
        tick();

        // 2: all-zero vector gives a single empty beat
        push0(0, 1, 1);
        send(0, 13'h0000);
        chk("t2_empty_flag", int'(empty0), 1);
        tick();
        chk_idle0("t2_end");

        // 3: full vector with idx_ready toggling, starting low
        for (int i = 0; i < 13; i++) push0(i, (i == 12), 0);
        send(0, 13'h1FFF);
        for (int c = 0; c < 26; c++) begin
            idx_ready = (c % 2 == 1);
            tick();
        end
        idx_ready = 1'b1;
        chk_idle0("t3_end");

        // 4: LSB scan, and a vector offered mid-scan is not taken
        push1(8, 0, 0); push1(10, 1, 0);
        send(1, 13'h0500);
        in_vec = 13'h0FFF;
        in_valid1 = 1'b1;
        chk("t4_ready_in_scan", int'(in_ready1), 0);
        tick();
        chk("t4_ready_in_scan2", int'(in_ready1), 0);
        in_valid1 = 1'b0;
        tick();
        chk("t4_idle_valid", int'(idx_valid1), 0);
        chk("t4_idle_ready", int'(in_ready1), 1);
        chk("t4_qempty", q1.size(), 0);

        // 5: flush on the edge consuming the second beat
        push0(3, 0, 0); push0(4, 0, 0);
        send(0, 13'h0314);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle0("t5_flush");
        push0(0, 1, 0);
        send(0, 13'h1000);
        tick();
        chk_idle0("t5_end");

        // 6: reset mid-scan, then replay
        push0(3, 0, 0);
        send(0, 13'h0314);
        tick();
        idx_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idx_ready = 1'b1;
        chk_idle0("t6_rst");
        chk("t6_outs", int'({idx0, last0, empty0}), 0);
        push0(3, 0, 0); push0(4, 0, 0); push0(8, 0, 0); push0(10, 1, 0);
        send(0, 13'h0314);
        repeat (4) tick();
        chk_idle0("t6_end");

        repeat (2) tick();
        chk("final_q0", q0.size(), 0);
        chk("final_q1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
